uart_tx_scheduler: RTL and testbench

// Shares the single UART TX frame engine between two result sources: ALU (16-bit result, sent as
// 2 bytes) and register file (8-bit read data, sent as 1 byte). Grants one requester round-robin,

---
 rtl/uart_tx_scheduler_pkg.sv | 23 ++
 rtl/uart_tx_scheduler_rr_arb2.sv | 34 +++
 rtl/uart_tx_scheduler.sv | 128 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART TX scheduler: state encodings, requester IDs
// and how many bytes each requester contributes to a transfer.
package uart_tx_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    SEND  = 2'd2
  } sched_state_t;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_RF  = 1'b1
  } req_id_t;

  localparam logic [1:0] ALU_BYTES = 2'd2;
  localparam logic [1:0] RF_BYTES  = 2'd1;

  function automatic logic [1:0] byte_count(input req_id_t id);
    return (id == REQ_ALU) ? ALU_BYTES : RF_BYTES;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arb2.sv
// Two-way round-robin arbiter. Bit 0 is the ALU, bit 1 the register file; the
// pointer remembers the last winner and only moves when the grant is taken.
module rr_arb2
  import uart_tx_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] grant,
  output req_id_t    last
);

  // On a tie the requester that did not win last time is favoured.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == REQ_RF) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Reset value REQ_RF makes the ALU the first winner of a tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= REQ_RF;
    end else if (take && (grant != 2'b00)) begin
      last <= grant[1] ? REQ_RF : REQ_ALU;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART TX frame engine between the ALU result path (two bytes, LSB
// first) and the register-file read path (one byte).
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_req,
  input  logic [2*DATA_WIDTH-1:0] alu_data,
  output logic                    alu_ack,
  input  logic                    rf_req,
  input  logic [DATA_WIDTH-1:0]   rf_data,
  output logic                    rf_ack,
  input  logic                    tx_busy,
  output logic                    tx_data_valid,
  output logic [DATA_WIDTH-1:0]   tx_p_data,
  output logic                    sched_busy,
  output logic                    tx_err
);

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

  sched_state_t            state, state_n;
  logic [2*DATA_WIDTH-1:0] buffer, buffer_n;
  logic [1:0]              bytes_left, bytes_n;
  logic [TW-1:0]           to_cnt, to_n;
  logic                    alu_ack_n, rf_ack_n, err_n;
  logic                    take;
  logic [1:0]              grant;
  req_id_t                 src;

  // The arbiter's last-grant pointer doubles as the source of the buffered transfer.
  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   ({rf_req, alu_req}),
    .take  (take),
    .grant (grant),
    .last  (src)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      buffer     <= '0;
      bytes_left <= '0;
      to_cnt     <= '0;
      alu_ack    <= 1'b0;
      rf_ack     <= 1'b0;
      tx_err     <= 1'b0;
    end else begin
      state      <= state_n;
      buffer     <= buffer_n;
      bytes_left <= bytes_n;
      to_cnt     <= to_n;
      alu_ack    <= alu_ack_n;
      rf_ack     <= rf_ack_n;
      tx_err     <= err_n;
    end
  end

  // DRAIN always precedes SEND so the UART finishes any earlier frame first and
  // tx_data_valid drops between the two ALU bytes.
  always_comb begin
    state_n   = state;
    buffer_n  = buffer;
    bytes_n   = bytes_left;
    to_n      = to_cnt;
    alu_ack_n = 1'b0;
    rf_ack_n  = 1'b0;
    err_n     = 1'b0;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (grant != 2'b00) begin
          take      = 1'b1;
          buffer_n  = grant[1] ? {{DATA_WIDTH{1'b0}}, rf_data} : alu_data;
          bytes_n   = byte_count(grant[1] ? REQ_RF : REQ_ALU);
          alu_ack_n = grant[0];
          rf_ack_n  = grant[1];
          state_n   = DRAIN;
        end
      end
      DRAIN: begin
        if (!tx_busy) begin
          if (bytes_left != 2'd0) begin
            to_n    = '0;
            state_n = SEND;
          end else begin
            state_n = IDLE;
          end
        end
      end
      SEND: begin
        if (tx_busy) begin
          bytes_n = bytes_left - 2'd1;
          state_n = DRAIN;
        end else if (to_cnt == TO_LAST) begin
          err_n   = 1'b1;
          bytes_n = 2'd0;
          state_n = IDLE;
        end else begin
          to_n = to_cnt + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs decode registered state only; the upper ALU byte goes out last.
  always_comb begin
    tx_data_valid = (state == SEND);
    sched_busy    = (state != IDLE);
    tx_p_data     = '0;
    if (state == SEND) begin
      if ((src == REQ_ALU) && (bytes_left == 2'd1)) begin
        tx_p_data = buffer[2*DATA_WIDTH-1:DATA_WIDTH];
      end else begin
        tx_p_data = buffer[DATA_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a simple UART TX model that raises
// busy one cycle after data_valid and holds it for 11 cycles.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_req = 1'b0;
  logic [15:0] alu_data = '0;
  logic        alu_ack;
  logic        rf_req = 1'b0;
  logic [7:0]  rf_data = '0;
  logic        rf_ack;
  logic        tx_busy;
  logic        tx_data_valid;
  logic [7:0]  tx_p_data;
  logic        sched_busy;
  logic        tx_err;

  logic        model_busy;
  logic        force_busy = 1'b0;
  logic        model_en = 1'b1;
  int          model_cnt;
  logic        valid_q;
  int          valid_rises = 0;
  logic [7:0]  sent_bytes[$];
  int          ack_log[$];

  int tests_run = 0;
  int tests_failed = 0;

  assign tx_busy = model_busy | force_busy;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.DATA_WIDTH(8), .ACK_TIMEOUT(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_req       (alu_req),
    .alu_data      (alu_data),
    .alu_ack       (alu_ack),
    .rf_req        (rf_req),
    .rf_data       (rf_data),
    .rf_ack        (rf_ack),
    .tx_busy       (tx_busy),
    .tx_data_valid (tx_data_valid),
    .tx_p_data     (tx_p_data),
    .sched_busy    (sched_busy),
    .tx_err        (tx_err)
  );

  // UART model plus logs of transmitted bytes, frame starts and ack order.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_busy <= 1'b0;
      model_cnt  <= 0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= tx_data_valid;
      if (tx_data_valid && !valid_q) valid_rises <= valid_rises + 1;
      if (alu_ack) ack_log.push_back(0);
      if (rf_ack) ack_log.push_back(1);
      if (model_cnt > 0) begin
        model_cnt  <= model_cnt - 1;
        model_busy <= (model_cnt > 1);
      end else if (model_en && tx_data_valid && !model_busy) begin
        sent_bytes.push_back(tx_p_data);
        model_busy <= 1'b1;
        model_cnt  <= 11;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic a_req, input logic [15:0] a_data,
                               input logic r_req, input logic [7:0] r_data);
    alu_req  = a_req;
    alu_data = a_data;
    rf_req   = r_req;
    rf_data  = r_data;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i;
    i = 0;
    while (sched_busy && i < budget) begin
      tick();
      i++;
    end
    checkOutput({tag, " idle"}, {31'd0, sched_busy}, 32'd0);
  endtask

  function automatic logic [31:0] byte_at(input int idx);
    if (idx < sent_bytes.size()) return {24'd0, sent_bytes[idx]};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ack_at(input int idx);
    if (idx < ack_log.size()) return ack_log[idx];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic reset_and_check(input string tag);
    rst = 1'b0;
    tick(2);
    checkOutput({tag, " outs"},
                {26'd0, alu_ack, rf_ack, tx_data_valid, sched_busy, tx_err, 1'b0},
                32'd0);
    checkOutput({tag, " data"}, {24'd0, tx_p_data}, 32'd0);
    rst = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base_b, base_r, base_a, i, cnt, bad, alu_cnt;
    logic rf_done, err_seen, busy_at_err, found;

    reset_and_check("reset");

    // 1: single RF byte
    base_b = sent_bytes.size();
    applyStimulus(0, 16'h0, 1, 8'hA5);
    tick();
    checkOutput("t1 rf_ack", {31'd0, rf_ack}, 32'd1);
    checkOutput("t1 valid+1", {31'd0, tx_data_valid}, 32'd0);
    applyStimulus(0, 16'h0, 0, 8'h00);
    tick();
    checkOutput("t1 valid+2", {31'd0, tx_data_valid}, 32'd1);
    checkOutput("t1 pdata", {24'd0, tx_p_data}, 32'hA5);
    wait_idle("t1", 60);
    checkOutput("t1 nbytes", sent_bytes.size() - base_b, 32'd1);
    checkOutput("t1 byte", byte_at(base_b), 32'hA5);

    // 2: ALU result, LSB first, two distinct frames
    base_b = sent_bytes.size();
    base_r = valid_rises;
    applyStimulus(1, 16'h1234, 0, 8'h00);
    tick();
    checkOutput("t2 alu_ack", {31'd0, alu_ack}, 32'd1);
    applyStimulus(0, 16'h0, 0, 8'h00);
    tick();
    checkOutput("t2 pdata0", {24'd0, tx_p_data}, 32'h34);
    wait_idle("t2", 100);
    checkOutput("t2 nbytes", sent_bytes.size() - base_b, 32'd2);
    checkOutput("t2 byte0", byte_at(base_b), 32'h34);
    checkOutput("t2 byte1", byte_at(base_b + 1), 32'h12);
    checkOutput("t2 frames", valid_rises - base_r, 32'd2);

    // 3: round-robin on simultaneous requests
    reset_and_check("t3 reset");
    base_b = sent_bytes.size();
    base_a = ack_log.size();
    applyStimulus(1, 16'hBEEF, 1, 8'h5A);
    alu_cnt = 0;
    rf_done = 1'b0;
    i = 0;
    while ((alu_cnt < 2 || !rf_done || sched_busy) && i < 300) begin
      tick();
      i++;
      if (alu_ack) begin
        alu_cnt++;
        if (alu_cnt == 1) alu_data = 16'hCAFE;
        else alu_req = 1'b0;
      end
      if (rf_ack) begin
        rf_done = 1'b1;
        rf_req  = 1'b0;
      end
    end
    checkOutput("t3 done", {31'd0, (i < 300)}, 32'd1);
    checkOutput("t3 ack0", ack_at(base_a), 32'd0);
    checkOutput("t3 ack1", ack_at(base_a + 1), 32'd1);
    checkOutput("t3 ack2", ack_at(base_a + 2), 32'd0);
    checkOutput("t3 byte0", byte_at(base_b), 32'hEF);
    checkOutput("t3 byte1", byte_at(base_b + 1), 32'hBE);
    checkOutput("t3 byte2", byte_at(base_b + 2), 32'h5A);
    checkOutput("t3 byte3", byte_at(base_b + 3), 32'hFE);
    checkOutput("t3 byte4", byte_at(base_b + 4), 32'hCA);

    // 4: UART still busy from an earlier frame
    base_b = sent_bytes.size();
    force_busy = 1'b1;
    applyStimulus(0, 16'h0, 1, 8'h3C);
    tick();
    checkOutput("t4 rf_ack", {31'd0, rf_ack}, 32'd1);
    applyStimulus(0, 16'h0, 0, 8'h00);
    bad = 0;
    repeat (19) begin
      tick();
      if (tx_data_valid) bad++;
    end
    checkOutput("t4 held valid", bad, 32'd0);
    checkOutput("t4 sched_busy", {31'd0, sched_busy}, 32'd1);
    force_busy = 1'b0;
    tick();
    checkOutput("t4 valid", {31'd0, tx_data_valid}, 32'd1);
    checkOutput("t4 pdata", {24'd0, tx_p_data}, 32'h3C);
    wait_idle("t4", 60);
    checkOutput("t4 byte", byte_at(base_b), 32'h3C);

    // 5: UART never acknowledges, frame aborted
    model_en = 1'b0;
    applyStimulus(1, 16'hA55A, 0, 8'h00);
    tick();
    checkOutput("t5 alu_ack", {31'd0, alu_ack}, 32'd1);
    applyStimulus(0, 16'h0, 0, 8'h00);
    cnt = 0;
    bad = 0;
    err_seen = 1'b0;
    busy_at_err = 1'b1;
    i = 0;
    while (!err_seen && i < 60) begin
      tick();
      i++;
      if (tx_data_valid) begin
        cnt++;
        if (tx_p_data != 8'h5A) bad++;
      end
      if (tx_err) begin
        err_seen = 1'b1;
        busy_at_err = sched_busy;
      end
    end
    checkOutput("t5 err seen", {31'd0, err_seen}, 32'd1);
    checkOutput("t5 send cycles", cnt, 32'd16);
    checkOutput("t5 stable data", bad, 32'd0);
    checkOutput("t5 idle at err", {31'd0, busy_at_err}, 32'd0);
    tick();
    checkOutput("t5 err pulse", {31'd0, tx_err}, 32'd0);
    bad = 0;
    repeat (20) begin
      tick();
      if (tx_data_valid) bad++;
    end
    checkOutput("t5 no 2nd byte", bad, 32'd0);
    model_en = 1'b1;

    // 6: reset during the second ALU byte
    applyStimulus(1, 16'h7788, 0, 8'h00);
    tick();
    checkOutput("t6 alu_ack", {31'd0, alu_ack}, 32'd1);
    applyStimulus(0, 16'h0, 0, 8'h00);
    found = 1'b0;
    i = 0;
    while (!found && i < 100) begin
      tick();
      i++;
      if (tx_data_valid && tx_p_data == 8'h77) found = 1'b1;
    end
    checkOutput("t6 2nd byte", {31'd0, found}, 32'd1);
    rst = 1'b0;
    tick();
    checkOutput("t6 reset outs",
                {18'd0, alu_ack, rf_ack, tx_data_valid, sched_busy, tx_err, tx_p_data, 1'b0},
                32'd0);
    rst = 1'b1;
    tick();
    base_b = sent_bytes.size();
    applyStimulus(0, 16'h0, 1, 8'h42);
    tick();
    checkOutput("t6 rf_ack", {31'd0, rf_ack}, 32'd1);
    applyStimulus(0, 16'h0, 0, 8'h00);
    wait_idle("t6", 60);
    checkOutput("t6 nbytes", sent_bytes.size() - base_b, 32'd1);
    checkOutput("t6 byte", byte_at(base_b), 32'h42);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
